// File: rtl/freq_gate_gen.sv
// Gate generator in front of the frequency event counter: synchronises sig_i,
// opens a gate of gate_len_i cycles on the first rising edge and emits count/stop pulses.
module freq_gate_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int GATE_W      = 32,
    parameter int TIMEOUT     = 1000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sig_i,
    input  logic              start_i,
    input  logic [GATE_W-1:0] gate_len_i,
    output logic              clk_cnt_o,
    output logic              clk_stop_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                r_sync_d;
    logic [GATE_W-1:0]   r_len;
    logic [GATE_W-1:0]   r_gcnt;
    logic [TMO_W-1:0]    r_tmo;

    logic w_rise;
    logic w_accept;
    logic w_gate_last;
    logic w_tmo_last;
    logic w_tmo_fire;
    logic w_cnt_nxt;
    logic w_stop_nxt;
    logic w_busy_nxt;
    logic w_done_nxt;
    logic w_timeout_nxt;

    assign w_rise      = r_sync[SYNC_STAGES-1] & ~r_sync_d;
    assign w_accept    = (r_state == S_IDLE) && start_i && (gate_len_i != '0);
    assign w_gate_last = (r_gcnt == (r_len - GATE_W'(1)));
    assign w_tmo_last  = (r_tmo == TMO_W'(TIMEOUT - 1));
    // An opening edge in the timeout cycle wins over the timeout.
    assign w_tmo_fire  = (r_state == S_ARM) && !w_rise && w_tmo_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], sig_i};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_len <= gate_len_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo  <= '0;
            r_gcnt <= '0;
        end else begin
            if (w_accept) begin
                r_tmo <= '0;
            end else if (r_state == S_ARM && !w_tmo_last) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
            if (r_state == S_ARM && w_rise) begin
                r_gcnt <= '0;
            end else if (r_state == S_GATE) begin
                r_gcnt <= r_gcnt + GATE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            clk_cnt_o  <= 1'b0;
            clk_stop_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            clk_cnt_o  <= w_cnt_nxt;
            clk_stop_o <= w_stop_nxt;
            busy_o     <= w_busy_nxt;
            done_o     <= w_done_nxt;
            timeout_o  <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_ARM;
            S_ARM: begin
                if (w_rise) begin
                    w_state_nxt = S_GATE;
                end else if (w_tmo_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_GATE: if (w_gate_last) w_state_nxt = S_DONE;
            default: w_state_nxt = S_DONE;
        endcase
    end

    // The last gate cycle drops its edge so count and stop never coincide.
    always_comb begin
        w_cnt_nxt     = (r_state == S_GATE) && w_rise && !w_gate_last;
        w_stop_nxt    = w_tmo_fire || ((r_state == S_GATE) && w_gate_last);
        w_busy_nxt    = (w_state_nxt == S_ARM) || (w_state_nxt == S_GATE);
        w_done_nxt    = (w_state_nxt == S_DONE);
        w_timeout_nxt = w_tmo_fire || ((r_state == S_DONE) && timeout_o);
    end

endmodule

// File: tb/tb_freq_gate_gen.sv
// Bench for freq_gate_gen: directed measurements whose expected count, duration and
// timeout flag are queued at issue time and checked by a monitor on each stop pulse.
module tb_freq_gate_gen;

    localparam int GATE_W = 32;

    typedef struct {
        int cnt;
        int dur;
        int tmo;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              sig_i = 1'b0;
    logic              start_i = 1'b0;
    logic [GATE_W-1:0] gate_len_i = '0;
    logic              clk_cnt_o;
    logic              clk_stop_o;
    logic              busy_o;
    logic              done_o;
    logic              timeout_o;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   sig_j = 0;
    bit   sig_on = 1'b0;

    int   m_cyc = 0;
    int   m_cnt = 0;
    bit   m_in = 1'b0;
    bit   m_prev_busy = 1'b0;
    exp_t m_e;

    freq_gate_gen #(
        .SYNC_STAGES(2),
        .GATE_W     (GATE_W),
        .TIMEOUT    (1000)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sig_i     (sig_i),
        .start_i   (start_i),
        .gate_len_i(gate_len_i),
        .clk_cnt_o (clk_cnt_o),
        .clk_stop_o(clk_stop_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock step; sig_i is period 10, high for the first 5 steps of each period.
    task automatic step();
        @(negedge clk);
        if (sig_on) begin
            sig_j++;
            sig_i = (((sig_j - 1) % 10) < 5);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sig_on  = 1'b0;
        sig_i   = 1'b0;
        start_i = 1'b0;
        steps(3);
        reset_n = 1'b1;
        steps(2);
    endtask

    task automatic start_meas(input int len, input bit periodic);
        step();
        start_i    = 1'b1;
        gate_len_i = GATE_W'(len);
        sig_j      = 0;
        sig_on     = periodic;
        step();
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (!done_o && i < budget) begin
            step();
            i++;
        end
        step();
        chk("done_reached", int'(done_o), 1);
    endtask

    task automatic push(input int cnt, input int dur, input int tmo);
        exp_t e;
        e.cnt = cnt;
        e.dur = dur;
        e.tmo = tmo;
        q.push_back(e);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_in        = 1'b0;
                m_prev_busy = 1'b0;
            end else begin
                if (busy_o && !m_prev_busy) begin
                    m_in  = 1'b1;
                    m_cyc = 0;
                    m_cnt = 0;
                end else if (m_in) begin
                    m_cyc++;
                end
                if (clk_cnt_o) begin
                    if (!m_in) chk("stray_cnt", 1, 0);
                    m_cnt++;
                end
                if (clk_stop_o) begin
                    if (q.size() == 0) begin
                        chk("unexpected_stop", 1, 0);
                    end else begin
                        m_e = q.pop_front();
                        chk("cnt_pulses", m_cnt, m_e.cnt);
                        chk("stop_cycle", m_cyc, m_e.dur);
                        chk("timeout_flag", int'(timeout_o), m_e.tmo);
                        chk("done_at_stop", int'(done_o), 1);
                        chk("busy_at_stop", int'(busy_o), 0);
                        chk("cnt_with_stop", int'(clk_cnt_o), 0);
                    end
                    m_in = 1'b0;
                end
                m_prev_busy = busy_o;
            end
        end
    end

    initial begin
        // Reset held while inputs toggle.
        gate_len_i = 32'd7;
        for (int i = 0; i < 6; i++) begin
            step();
            sig_i   = ~sig_i;
            start_i = ~start_i;
            chk("rst_outputs", int'({clk_cnt_o, clk_stop_o, busy_o, done_o, timeout_o}), 0);
        end
        start_i = 1'b0;
        sig_i   = 1'b0;
        reset_n = 1'b1;
        steps(2);
        chk("idle_busy", int'(busy_o), 0);
        chk("idle_done", int'(done_o), 0);

        // Zero-length request is ignored.
        start_meas(0, 1'b1);
        steps(20);
        chk("len0_busy", int'(busy_o), 0);
        chk("len0_done", int'(done_o), 0);

        // Nominal gate of 100 cycles.
        do_reset();
        push(9, 103, 0);
        start_meas(100, 1'b1);
        wait_done(3000);
        steps(40);
        chk("nominal_done_hold", int'(done_o), 1);
        chk("nominal_tmo_hold", int'(timeout_o), 0);

        // Edge in the last gate cycle is suppressed.
        do_reset();
        push(0, 13, 0);
        start_meas(10, 1'b1);
        wait_done(3000);

        // Restart during GATE with another length has no effect.
        do_reset();
        push(9, 103, 0);
        start_meas(100, 1'b1);
        steps(29);
        start_i    = 1'b1;
        gate_len_i = 32'd20;
        step();
        start_i    = 1'b0;
        wait_done(3000);

        // Timeout with sig_i held low, then a start while in DONE.
        do_reset();
        push(0, 1000, 1);
        start_meas(50, 1'b0);
        wait_done(3000);
        start_meas(5, 1'b1);
        steps(30);
        chk("done_start_done", int'(done_o), 1);
        chk("done_start_busy", int'(busy_o), 0);
        chk("done_start_tmo", int'(timeout_o), 1);

        // Reset at gate cycle 500 of a 1000-cycle gate, then a full rerun.
        do_reset();
        start_meas(1000, 1'b1);
        steps(503);
        chk("midgate_busy_before", int'(busy_o), 1);
        reset_n = 1'b0;
        #1;
        chk("midgate_rst_outputs", int'({clk_cnt_o, clk_stop_o, busy_o, done_o, timeout_o}), 0);
        sig_on = 1'b0;
        sig_i  = 1'b0;
        steps(4);
        chk("midgate_rst_hold", int'({clk_cnt_o, clk_stop_o, busy_o, done_o, timeout_o}), 0);
        reset_n = 1'b1;
        steps(2);
        push(99, 1003, 0);
        start_meas(1000, 1'b1);
        wait_done(3000);

        steps(3);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
